// File: rtl/frame_streamer.sv
// Double-buffered 128x64 OLED framebuffer: user writes land in the back bank while
// the front bank is streamed out in SSD1306 horizontal-addressing order.
module frame_streamer #(
    parameter int FRAME_BYTES = 1024,
    parameter int ADDR_W      = 10,
    parameter int COL_W       = 7
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [7:0]              wr_data_i,
    input  logic                    swap_req_i,
    input  logic                    frame_req_i,
    output logic                    byte_valid_o,
    output logic [7:0]              byte_data_o,
    input  logic                    byte_ready_i,
    output logic                    byte_last_o,
    output logic [COL_W-1:0]        col_o,
    output logic [ADDR_W-COL_W-1:0] page_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    swap_pending_o,
    output logic                    front_sel_o
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PRESENT, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        bank0 [FRAME_BYTES];
    logic [7:0]        bank1 [FRAME_BYTES];
    logic [7:0]        rd_q;
    logic [ADDR_W-1:0] addr;
    logic              start, is_last;

    assign start        = (state == IDLE) && frame_req_i;
    assign is_last      = (addr == ADDR_W'(FRAME_BYTES - 1));
    assign busy_o       = (state != IDLE);
    assign frame_done_o = (state == DONE);
    assign col_o        = addr[COL_W-1:0];
    assign page_o       = addr[ADDR_W-1:COL_W];

    // Storage is never reset; writes use the pre-edge front_sel_o so a write in the
    // swap cycle lands in the bank that was the back buffer before the swap.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (front_sel_o) bank0[wr_addr_i] <= wr_data_i;
            else             bank1[wr_addr_i] <= wr_data_i;
        end
        rd_q <= front_sel_o ? bank1[addr] : bank0[addr];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_req_i) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = PRESENT;
            PRESENT: if (byte_ready_i) state_nxt = is_last ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr           <= '0;
            byte_valid_o   <= 1'b0;
            byte_data_o    <= 8'h00;
            byte_last_o    <= 1'b0;
            front_sel_o    <= 1'b0;
            swap_pending_o <= 1'b0;
        end else begin
            // A swap requested in the accepting cycle applies to that same frame.
            if (start) begin
                addr <= '0;
                if (swap_pending_o || swap_req_i) begin
                    front_sel_o    <= ~front_sel_o;
                    swap_pending_o <= 1'b0;
                end
            end else if (swap_req_i) begin
                swap_pending_o <= 1'b1;
            end

            case (state)
                LOAD: begin
                    byte_data_o  <= rd_q;
                    byte_valid_o <= 1'b1;
                    byte_last_o  <= is_last;
                end
                PRESENT: if (byte_ready_i) begin
                    byte_valid_o <= 1'b0;
                    byte_last_o  <= 1'b0;
                    if (!is_last) addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
